ibex_rf_wb_arbiter: RTL and testbench

//  Write-back stage directly upstream of the latch-based register file. Merges two write

---
 rtl/ibex_rf_wb_arbiter.sv | 155 +++++++++++++++
 tb/tb_ibex_rf_wb_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ibex_rf_wb_arbiter.sv
// Write-back arbiter for the register file write port.
// Load data always wins the port; execute results take the FIFO head or bypass it
// when it is empty. Forwarding covers writes not yet visible in the RF.
module ibex_rf_wb_arbiter #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 2,
  parameter bit          RV32E     = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ex_valid_i,
  output logic                 ex_ready_o,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  input  logic                 lsu_valid_i,
  input  logic [4:0]           lsu_waddr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  input  logic [4:0]           fwd_raddr_a_i,
  output logic                 fwd_hit_a_o,
  output logic [DataWidth-1:0] fwd_data_a_o,
  input  logic [4:0]           fwd_raddr_b_i,
  output logic                 fwd_hit_b_o,
  output logic [DataWidth-1:0] fwd_data_b_o,
  output logic                 buf_empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  typedef struct packed {
    logic [4:0]           addr;
    logic [DataWidth-1:0] data;
  } wb_t;

  // Register zero detection, honouring the reduced register file.
  function automatic logic is_x0(input logic [4:0] a);
    return RV32E ? (a[3:0] == 4'd0) : (a == 5'd0);
  endfunction

  // Register address compare, honouring the reduced register file.
  function automatic logic addr_eq(input logic [4:0] a, input logic [4:0] b);
    return RV32E ? (a[3:0] == b[3:0]) : (a == b);
  endfunction

  // Pointer increment with wrap at Depth.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (32'(p) == Depth - 1) ? '0 : p + PtrW'(1);
  endfunction

  wb_t             fifo_q [Depth];
  logic [Depth-1:0] valid_q, valid_d;
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic lsu_wr, ex_wr, fifo_empty, push, pop, out_we_d;
  wb_t  out_d, ex_entry;

  assign ex_ready_o  = (count_q < CntW'(Depth));
  assign fifo_empty  = (count_q == '0);
  assign buf_empty_o = fifo_empty & ~rf_we_o;
  assign ex_entry    = '{addr: ex_waddr_i, data: ex_wdata_i};

  // Write-port selection and FIFO bookkeeping.
  always_comb begin
    lsu_wr   = lsu_valid_i & ~is_x0(lsu_waddr_i);
    ex_wr    = ex_valid_i & ex_ready_o & ~is_x0(ex_waddr_i);
    push     = 1'b0;
    pop      = 1'b0;
    out_we_d = 1'b0;
    out_d    = '{addr: rf_waddr_o, data: rf_wdata_o};
    if (lsu_wr) begin
      out_we_d = 1'b1;
      out_d    = '{addr: lsu_waddr_i, data: lsu_wdata_i};
      push     = ex_wr;
    end else if (!fifo_empty) begin
      out_we_d = 1'b1;
      out_d    = fifo_q[rptr_q];
      pop      = 1'b1;
      push     = ex_wr;
    end else if (ex_wr) begin
      out_we_d = 1'b1;
      out_d    = ex_entry;
    end
    wptr_d  = push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d  = pop ? ptr_inc(rptr_q) : rptr_q;
    count_d = count_q + CntW'(push) - CntW'(pop);
    valid_d = valid_q;
    if (pop)  valid_d[rptr_q] = 1'b0;
    if (push) valid_d[wptr_q] = 1'b1;
  end

  // Pointers, occupancy and the registered RF write port.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      rf_we_o    <= out_we_d;
      rf_waddr_o <= out_d.addr;
      rf_wdata_o <= out_d.data;
    end
  end

  // FIFO payload storage; validity is tracked separately so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wptr_q] <= ex_entry;
    end
  end

  logic [4:0]           fwd_addr [2];
  logic                 fwd_hit  [2];
  logic [DataWidth-1:0] fwd_data [2];

  assign fwd_addr[0]  = fwd_raddr_a_i;
  assign fwd_addr[1]  = fwd_raddr_b_i;
  assign fwd_hit_a_o  = fwd_hit[0];
  assign fwd_data_a_o = fwd_data[0];
  assign fwd_hit_b_o  = fwd_hit[1];
  assign fwd_data_b_o = fwd_data[1];

  // Forwarding: scan oldest to youngest so the youngest match overrides.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      fwd_hit[p]  = 1'b0;
      fwd_data[p] = '0;
      if (!is_x0(fwd_addr[p])) begin
        if (rf_we_o && addr_eq(rf_waddr_o, fwd_addr[p])) begin
          fwd_hit[p]  = 1'b1;
          fwd_data[p] = rf_wdata_o;
        end
        for (int unsigned k = 0; k < Depth; k++) begin
          if (valid_q[PtrW'((32'(rptr_q) + k) % Depth)] &&
              addr_eq(fifo_q[PtrW'((32'(rptr_q) + k) % Depth)].addr, fwd_addr[p])) begin
            fwd_hit[p]  = 1'b1;
            fwd_data[p] = fifo_q[PtrW'((32'(rptr_q) + k) % Depth)].data;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ibex_rf_wb_arbiter.sv
// Directed bench for ibex_rf_wb_arbiter: RF write order via a scoreboard queue,
// plus latency, handshake, forwarding, x0 and reset checks.
module tb_ibex_rf_wb_arbiter;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ex_valid, ex_ready;
  logic [4:0]    ex_waddr;
  logic [DW-1:0] ex_wdata;
  logic          lsu_valid;
  logic [4:0]    lsu_waddr;
  logic [DW-1:0] lsu_wdata;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [4:0]    fwd_raddr_a, fwd_raddr_b;
  logic          fwd_hit_a, fwd_hit_b;
  logic [DW-1:0] fwd_data_a, fwd_data_b;
  logic          buf_empty;

  int errors = 0;
  int checks = 0;
  logic [36:0] sb_q [$];

  always #5 clk = ~clk;

  ibex_rf_wb_arbiter #(.DataWidth(32), .Depth(2), .RV32E(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ex_valid_i(ex_valid), .ex_ready_o(ex_ready), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata),
    .lsu_valid_i(lsu_valid), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .fwd_raddr_a_i(fwd_raddr_a), .fwd_hit_a_o(fwd_hit_a), .fwd_data_a_o(fwd_data_a),
    .fwd_raddr_b_i(fwd_raddr_b), .fwd_hit_b_o(fwd_hit_b), .fwd_data_b_o(fwd_data_b),
    .buf_empty_o(buf_empty)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid  = 1'b0;
    lsu_valid = 1'b0;
  endtask

  task automatic drive(input logic lv, input logic [4:0] la, input logic [DW-1:0] ld,
                       input logic ev, input logic [4:0] ea, input logic [DW-1:0] ed);
    lsu_valid = lv; lsu_waddr = la; lsu_wdata = ld;
    ex_valid  = ev; ex_waddr  = ea; ex_wdata  = ed;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [DW-1:0] d);
    sb_q.push_back({a, d});
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (!(buf_empty === 1'b1) && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_drained"}, 64'(buf_empty), 64'd1);
    chk({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
  endtask

  // Scoreboard: every RF write must match the next expected write in order.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rf_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_rf_write", {27'd0, rf_waddr, rf_wdata}, 64'd0);
      end else begin
        chk("rf_write_order", {27'd0, rf_waddr, rf_wdata}, {27'd0, sb_q.pop_front()});
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    fwd_raddr_a = 5'd0;
    fwd_raddr_b = 5'd0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_waddr", 64'(rf_waddr), 64'd0);
    chk("rst_wdata", 64'(rf_wdata), 64'd0);
    chk("rst_ready", 64'(ex_ready), 64'd1);
    chk("rst_empty", 64'(buf_empty), 64'd1);

    // Bypass: one-cycle latency with empty FIFO.
    drive(1'b0, 5'd0, '0, 1'b1, 5'd5, 32'hA5A5_0001);
    #1 chk("byp_ready", 64'(ex_ready), 64'd1);
    expect_wr(5'd5, 32'hA5A5_0001);
    tick();
    idle();
    chk("byp_we", 64'(rf_we), 64'd1);
    chk("byp_waddr", 64'(rf_waddr), 64'd5);
    chk("byp_wdata", 64'(rf_wdata), 64'hA5A5_0001);
    fwd_raddr_a = 5'd5;
    #1 chk("byp_fwd", {31'd0, fwd_hit_a, fwd_data_a}, {31'd1, 32'hA5A5_0001});
    tick();
    chk("byp_we_off", 64'(rf_we), 64'd0);
    chk("byp_empty", 64'(buf_empty), 64'd1);

    // Collision: load wins, execute result buffered and forwarded.
    drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
    expect_wr(5'd3, 32'h11);
    expect_wr(5'd4, 32'h22);
    tick();
    idle();
    chk("col_waddr1", 64'(rf_waddr), 64'd3);
    chk("col_empty", 64'(buf_empty), 64'd0);
    fwd_raddr_a = 5'd4;
    #1 chk("col_fwd_x4", {31'd0, fwd_hit_a, fwd_data_a}, {31'd1, 32'h22});
    tick();
    chk("col_waddr2", {27'd0, rf_waddr, rf_wdata}, {27'd0, 5'd4, 32'h22});
    drain("col");

    // Full: three back-to-back loads while execute stays valid.
    drive(1'b1, 5'd10, 32'h100, 1'b1, 5'd11, 32'h111);
    expect_wr(5'd10, 32'h100);
    expect_wr(5'd12, 32'h200);
    expect_wr(5'd14, 32'h300);
    expect_wr(5'd11, 32'h111);
    expect_wr(5'd13, 32'h113);
    expect_wr(5'd15, 32'h115);
    #1 chk("full_ready0", 64'(ex_ready), 64'd1);
    tick();
    drive(1'b1, 5'd12, 32'h200, 1'b1, 5'd13, 32'h113);
    #1 chk("full_ready1", 64'(ex_ready), 64'd1);
    tick();
    drive(1'b1, 5'd14, 32'h300, 1'b1, 5'd15, 32'h115);
    fwd_raddr_a = 5'd11;
    fwd_raddr_b = 5'd13;
    #1 chk("full_ready2", 64'(ex_ready), 64'd0);
    chk("full_fwd_a", {31'd0, fwd_hit_a, fwd_data_a}, {31'd1, 32'h111});
    chk("full_fwd_b", {31'd0, fwd_hit_b, fwd_data_b}, {31'd1, 32'h113});
    tick();
    lsu_valid = 1'b0;
    #1 chk("full_ready3", 64'(ex_ready), 64'd0);
    tick();
    #1 chk("full_ready4", 64'(ex_ready), 64'd1);
    tick();
    idle();
    drain("full");

    // Youngest wins: two buffered writes to x7.
    drive(1'b1, 5'd20, 32'h5, 1'b1, 5'd7, 32'h1);
    expect_wr(5'd20, 32'h5);
    expect_wr(5'd21, 32'h6);
    expect_wr(5'd7, 32'h1);
    expect_wr(5'd7, 32'h2);
    tick();
    drive(1'b1, 5'd21, 32'h6, 1'b1, 5'd7, 32'h2);
    tick();
    idle();
    fwd_raddr_a = 5'd7;
    #1 chk("yw_fwd_fifo", {31'd0, fwd_hit_a, fwd_data_a}, {31'd1, 32'h2});
    tick();
    #1 chk("yw_fwd_mixed", {31'd0, fwd_hit_a, fwd_data_a}, {31'd1, 32'h2});
    drain("yw");
    chk("yw_final", {27'd0, rf_waddr, rf_wdata}, {27'd0, 5'd7, 32'h2});

    // x0 writes: handshake completes, nothing reaches the RF.
    drive(1'b1, 5'd0, 32'hBEEF, 1'b1, 5'd0, 32'hDEAD);
    #1 chk("x0_ready", 64'(ex_ready), 64'd1);
    tick();
    idle();
    chk("x0_we", 64'(rf_we), 64'd0);
    chk("x0_empty", 64'(buf_empty), 64'd1);
    chk("x0_hold", {27'd0, rf_waddr, rf_wdata}, {27'd0, 5'd7, 32'h2});
    fwd_raddr_a = 5'd0;
    #1 chk("x0_fwd", {31'd0, fwd_hit_a, fwd_data_a}, 64'd0);

    // Reset with two buffered entries discards them.
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
    expect_wr(5'd1, 32'h1);
    expect_wr(5'd3, 32'h3);
    tick();
    drive(1'b1, 5'd3, 32'h3, 1'b1, 5'd4, 32'h4);
    tick();
    idle();
    chk("rs_full", 64'(ex_ready), 64'd0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rs_we", 64'(rf_we), 64'd0);
    chk("rs_ready", 64'(ex_ready), 64'd1);
    chk("rs_empty", 64'(buf_empty), 64'd1);
    fwd_raddr_a = 5'd2;
    #1 chk("rs_fwd", 64'(fwd_hit_a), 64'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("rs_no_write", 64'(rf_we), 64'd0);
    chk("rs_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
